apb_slave_regbank: RTL and testbench
====================================

// Module: apb_slave_regbank
// PURPOSE
// - APB completer (slave) register bank: the responder on the same APB bus our APB master drives.
// - Decodes PADDR into NUM_REGS 32-bit word registers and applies byte-lane writes via PSTRB.
// - Inserts programmable wait states and flags illegal accesses with PSLVERR.
// - Exposes all register contents to core logic.
// PARAMETERS
// ADDR_WIDTH  8             byte address width of PADDR
// DATA_WIDTH  32            data width; PSTRB width = DATA_WIDTH/8
// NUM_REGS    16            word registers; must be <= 2**(ADDR_WIDTH-2)
// ID_VALUE    32'hA9B0_0001 read-only contents of reg 0
// PORTS
// PCLK       in   1                    clock; all logic on rising edge
// PRESETn    in   1                    reset, asynchronous, active-low
// PADDR      in   ADDR_WIDTH           byte address; word index = PADDR[ADDR_WIDTH-1:2]
// PSEL       in   1                    slave select
// PENABLE    in   1                    access phase
// PWRITE     in   1                    1=write, 0=read
// PWDATA     in   DATA_WIDTH           write data
// PSTRB      in   DATA_WIDTH/8         byte write strobes
// PRDATA     out  DATA_WIDTH           read data; valid only when PREADY=1 and read
// PREADY     out  1                    transfer completes this cycle
// PSLVERR    out  1                    error; valid only when PREADY=1
// wait_cfg   in   4                    wait states per access, sampled in SETUP
// status_in  in   DATA_WIDTH           live value returned by read-only reg 1
// regs_out   out  NUM_REGS*DATA_WIDTH  flattened reg contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
// wr_pulse   out  1                    1-cycle pulse after a committed write
// wr_index   out  $clog2(NUM_REGS)     index of the last committed write
// BEHAVIOUR
// - Reset (async): FSM=IDLE; wait counter=0; regs 2..NUM_REGS-1=0; wr_pulse=0; wr_index=0.
//   PREADY/PSLVERR/PRDATA evaluate to 0. A reset mid-transfer aborts it with no write.
// - FSM states: IDLE, ACCESS.
//   - IDLE->ACCESS on PSEL&!PENABLE (SETUP). Latch PADDR, PWRITE, PWDATA, PSTRB.
//     Load cnt<=wait_cfg.
//   - ACCESS with PSEL&PENABLE and cnt!=0: cnt decrements; PREADY=0.
//   - ACCESS with PSEL&PENABLE and cnt==0: PREADY=1 (combinational from state and cnt);
//     next state IDLE.
//   - ACCESS with PSEL=0: aborted; go to IDLE; no write.
// - Latency: PREADY is first high wait_cfg cycles after the first ACCESS cycle.
//   wait_cfg=0 gives a zero-wait 2-cycle transfer.
// - Back-to-back: a SETUP in the cycle after completion is accepted from IDLE.
// - Protocol violation (IDLE with PSEL&PENABLE): PREADY=1, PSLVERR=1, PRDATA=0, no write.
// - Error when idx>=NUM_REGS, or PADDR[1:0]!=0, or write to reg 0 or 1.
//   - PSLVERR=PREADY&err.
//   - An erroring write changes nothing; an erroring read returns PRDATA=0.
// - Read data: reg 0 -> ID_VALUE; reg 1 -> status_in (sampled in the completing cycle);
//   others -> stored value.
//   PRDATA=0 whenever !(PREADY & !PWRITE).
// - Write commit: at the edge ending the completing cycle when PWRITE & !err.
//   - Lane b updates iff PSTRB[b]; PSTRB=0 gives a legal no-op write.
//   - wr_pulse=1 for the following cycle; wr_index=idx.
//   - wr_pulse=0 for an erroring write.
// - Only latched values are used; wait_cfg changes during ACCESS have no effect.
// STRUCTURE
// - Package apb_pkg: state enum {IDLE,ACCESS}; STRB_W=DATA_WIDTH/8; word-index helper;
//   ID/status register index constants.
// - One sub-module: apb_regbank_mem. Holds NUM_REGS x DATA_WIDTH storage with byte-strobe
//   write port and async read mux. The top level holds the FSM, wait counter, decode
//   and error logic.
// TESTING
// 1 Reset, then read 0x00 with wait_cfg=0 -> PREADY in 1st ACCESS cycle, PRDATA=32'hA9B0_0001, PSLVERR=0.
// 2 Write 0x08=32'hDEADBEEF, PSTRB=4'b0101; then read 0x08 -> 32'h00AD00EF; wr_pulse once with wr_index=2.
// 3 wait_cfg=3, read 0x0C -> PREADY low 3 ACCESS cycles, high on 4th; next SETUP accepted next cycle.
// 4 Write 0x40 (idx 16), write 0x04, read 0x09 -> each PSLVERR=1 with PREADY; no reg change; no wr_pulse.
// 5 PSEL dropped mid-wait (wait_cfg=5) on a write to 0x10 -> reg 4 unchanged; FSM IDLE.
// 6 PRESETn low during ACCESS of a write to 0x14 -> PREADY=0 immediately; reg 5=0 after release.

Source files
------------

// File: rtl/apb_slave_regbank_pkg.sv
// APB register bank shared types: FSM state encoding, lane count, fixed register indices.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package apb_pkg;

  // Completer FSM: IDLE waits for SETUP, ACCESS counts wait states until completion
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int STRB_W         = DATA_WIDTH_DEF / 8;

  // Reg 0 is the read-only ID word, reg 1 mirrors live status from the core
  localparam int ID_REG_IDX     = 0;
  localparam int STATUS_REG_IDX = 1;

  // Byte address to word index; callers zero-extend narrower addresses
  function automatic logic [31:0] word_idx(input logic [31:0] byte_addr);
    return {2'b00, byte_addr[31:2]};
  endfunction

endpackage

// File: rtl/apb_regbank_mem.sv
// Register storage: byte-strobed write port, combinational read mux, flattened view for the core.
// Latency: write lands at the clock edge with wr_en high; reads are combinational.
// Backpressure: none; the caller only asserts wr_en for a committed, legal write.
module apb_regbank_mem
  import apb_pkg::*;
#(
  parameter int                    NUM_REGS   = 16,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001,
  parameter int                    IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic                           wr_en,
  input  logic [IDX_W-1:0]               wr_idx,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_strb,
  input  logic [DATA_WIDTH-1:0]          status_in,
  input  logic [IDX_W-1:0]               rd_idx,
  output logic [DATA_WIDTH-1:0]          rd_data,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

  logic [DATA_WIDTH-1:0] words [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ID_REG_IDX) begin : g_id
      assign words[i] = ID_VALUE;
    end else if (i == STATUS_REG_IDX) begin : g_status
      assign words[i] = status_in;
    end else begin : g_rw
      localparam logic [IDX_W-1:0] MY_IDX = IDX_W'(i);
      logic [DATA_WIDTH-1:0] q;

      // Byte-lane update of this word; unstrobed lanes hold their value
      always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
          q <= '0;
        end else if (wr_en && (wr_idx == MY_IDX)) begin
          for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (wr_strb[b]) q[b*8 +: 8] <= wr_data[b*8 +: 8];
          end
        end
      end

      assign words[i] = q;
    end

    assign regs_flat[i*DATA_WIDTH +: DATA_WIDTH] = words[i];
  end

  // Read mux; out-of-range indices return zero (only reachable for non-power-of-2 banks)
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_REGS) rd_data = words[rd_idx];
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB completer register bank with programmable wait states and PSLVERR on illegal accesses.
// Latency: PREADY rises wait_cfg cycles after the first ACCESS cycle (2-cycle transfer at wait_cfg=0).
// Backpressure: PREADY held low while the latched wait count drains; PSEL drop aborts without a write.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA9B0_0001
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  input  logic [3:0]                     wait_cfg,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                           wr_pulse,
  output logic [$clog2(NUM_REGS)-1:0]    wr_index
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int LANES = DATA_WIDTH / 8;

  apb_state_e            state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [LANES-1:0]      strb_q;

  logic [31:0]           idx_full;
  logic [IDX_W-1:0]      idx;
  logic                  err;
  logic                  access_done;
  logic                  proto_err;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;

  // Decode works only on values latched in SETUP so mid-transfer bus changes are ignored
  assign idx_full = word_idx(32'(addr_q));
  assign idx      = idx_full[IDX_W-1:0];
  assign err      = (idx_full >= NUM_REGS) || (addr_q[1:0] != 2'b00) ||
                    (write_q && ((idx_full == ID_REG_IDX) || (idx_full == STATUS_REG_IDX)));

  // Gating with PRESETn keeps the bus quiet while reset is asserted mid-transfer
  assign access_done = PRESETn && (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
  assign proto_err   = PRESETn && (state_q == IDLE) && PSEL && PENABLE;
  assign commit      = access_done && write_q && !err;

  assign PREADY  = access_done || proto_err;
  assign PSLVERR = (access_done && err) || proto_err;
  assign PRDATA  = (access_done && !write_q && !err) ? rd_data : '0;

  // Transfer FSM: latch the request in SETUP, drain wait states, complete or abort
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state_q <= ACCESS;
            cnt_q   <= wait_cfg;
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_q <= IDLE;
          end else if (PENABLE) begin
            if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
            else               state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write notification to the core, one cycle after the commit edge
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_pulse <= 1'b0;
      wr_index <= '0;
    end else begin
      wr_pulse <= commit;
      if (commit) wr_index <= idx;
    end
  end

  apb_regbank_mem #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_VALUE   (ID_VALUE),
    .IDX_W      (IDX_W)
  ) u_mem (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .wr_en     (commit),
    .wr_idx    (idx),
    .wr_data   (wdata_q),
    .wr_strb   (strb_q),
    .status_in (status_in),
    .rd_idx    (idx),
    .rd_data   (rd_data),
    .regs_flat (regs_out)
  );

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: reset, ID/status reads, strobed writes, wait states, errors, abort, reset mid-transfer.
// Inputs driven on the falling edge, outputs sampled 1ns later.
// Every expected value is a hand-computed constant.
module tb_apb_slave_regbank;

  logic         PCLK;
  logic         PRESETn;
  logic [7:0]   PADDR;
  logic         PSEL;
  logic         PENABLE;
  logic         PWRITE;
  logic [31:0]  PWDATA;
  logic [3:0]   PSTRB;
  logic [31:0]  PRDATA;
  logic         PREADY;
  logic         PSLVERR;
  logic [3:0]   wait_cfg;
  logic [31:0]  status_in;
  logic [511:0] regs_out;
  logic         wr_pulse;
  logic [3:0]   wr_index;

  int checks = 0;
  int errors = 0;

  apb_slave_regbank dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .PADDR     (PADDR),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR),
    .wait_cfg  (wait_cfg),
    .status_in (status_in),
    .regs_out  (regs_out),
    .wr_pulse  (wr_pulse),
    .wr_index  (wr_index)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // One complete transfer: SETUP, then ACCESS until PREADY or the cycle budget expires
  task automatic apb_xfer(input logic [7:0] addr, input logic wr, input logic [31:0] wd,
                          input logic [3:0] st, output logic [31:0] rd, output logic err,
                          output int waits);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wd; PSTRB = st;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 40) begin
      @(negedge PCLK);
      #1;
      waits++;
    end
    checks++;
    if (PREADY !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout addr=%h: PREADY=%b after %0d waits, required 1", addr, PREADY, waits);
    end
    rd  = PRDATA;
    err = PSLVERR;
  endtask

  task automatic idle_cycle();
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err; int waits;
    PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0; PSTRB = '0;
    wait_cfg = 4'd0; status_in = 32'h1234_5678;
    repeat (2) @(negedge PCLK);
    #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b need 0", PREADY); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b need 0", PSLVERR); end
    checks++; if (PRDATA !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h need 0", PRDATA); end
    checks++; if (wr_pulse !== 1'b0 || wr_index !== 4'd0) begin
      errors++; $display("FAIL rst_wr: got pulse=%b idx=%0d need 0/0", wr_pulse, wr_index); end
    checks++; if (regs_out[2*32 +: 32] !== 32'h0) begin
      errors++; $display("FAIL rst_reg2: got %h need 0", regs_out[2*32 +: 32]); end
    @(negedge PCLK);
    PRESETn = 1'b1;
    apb_xfer(8'h00, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (waits !== 0) begin errors++; $display("FAIL id_latency: got %0d waits need 0", waits); end
    checks++; if (rd !== 32'hA9B0_0001) begin errors++; $display("FAIL id_read: got %h need a9b00001", rd); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL id_err: got %b need 0", err); end
    idle_cycle();
  endtask

  task automatic test_strobe_write();
    logic [31:0] rd; logic err; int waits;
    apb_xfer(8'h08, 1'b1, 32'hDEAD_BEEF, 4'b0101, rd, err, waits);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wr2_err: got %b need 0", err); end
    idle_cycle();
    checks++; if (wr_pulse !== 1'b1 || wr_index !== 4'd2) begin
      errors++; $display("FAIL wr2_pulse: got pulse=%b idx=%0d need 1/2", wr_pulse, wr_index); end
    idle_cycle();
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL wr2_pulse_once: got %b need 0", wr_pulse); end
    apb_xfer(8'h08, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (rd !== 32'h00AD_00EF) begin errors++; $display("FAIL rd2: got %h need 00ad00ef", rd); end
    checks++; if (regs_out[2*32 +: 32] !== 32'h00AD_00EF) begin
      errors++; $display("FAIL regs_out2: got %h need 00ad00ef", regs_out[2*32 +: 32]); end
    // Zero strobes: legal no-op write, still announced
    apb_xfer(8'h08, 1'b1, 32'hFFFF_FFFF, 4'b0000, rd, err, waits);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL nop_err: got %b need 0", err); end
    idle_cycle();
    checks++; if (wr_pulse !== 1'b1) begin errors++; $display("FAIL nop_pulse: got %b need 1", wr_pulse); end
    checks++; if (regs_out[2*32 +: 32] !== 32'h00AD_00EF) begin
      errors++; $display("FAIL nop_reg2: got %h need 00ad00ef", regs_out[2*32 +: 32]); end
    idle_cycle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic err; int waits;
    wait_cfg = 4'd3;
    apb_xfer(8'h0C, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (waits !== 3) begin errors++; $display("FAIL wait3_latency: got %0d waits need 3", waits); end
    checks++; if (rd !== 32'h0 || err !== 1'b0) begin
      errors++; $display("FAIL wait3_read: got %h err=%b need 0 err=0", rd, err); end
    // Back-to-back: SETUP in the very next cycle, reading live status
    apb_xfer(8'h04, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (waits !== 3 || err !== 1'b0) begin
      errors++; $display("FAIL b2b: got waits=%0d err=%b need 3/0", waits, err); end
    checks++; if (rd !== 32'h1234_5678) begin errors++; $display("FAIL status_read: got %h need 12345678", rd); end
    wait_cfg = 4'd0;
    idle_cycle();
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err; int waits;
    apb_xfer(8'h40, 1'b1, 32'h1111_1111, 4'hF, rd, err, waits);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_range: got %b need 1", err); end
    idle_cycle();
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL err_range_pulse: got %b need 0", wr_pulse); end
    apb_xfer(8'h04, 1'b1, 32'h2222_2222, 4'hF, rd, err, waits);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_ro_write: got %b need 1", err); end
    idle_cycle();
    checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL err_ro_pulse: got %b need 0", wr_pulse); end
    apb_xfer(8'h09, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (err !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_unaligned: got err=%b rd=%h need 1/0", err, rd); end
    idle_cycle();
    checks++; if (regs_out[2*32 +: 32] !== 32'h00AD_00EF) begin
      errors++; $display("FAIL err_reg2: got %h need 00ad00ef", regs_out[2*32 +: 32]); end
    // ACCESS-phase signals seen while IDLE
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h00; PWRITE = 1'b0;
    #1;
    checks++; if (PREADY !== 1'b1 || PSLVERR !== 1'b1 || PRDATA !== 32'h0) begin
      errors++; $display("FAIL proto: got rdy=%b err=%b rd=%h need 1/1/0", PREADY, PSLVERR, PRDATA); end
    idle_cycle();
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err; int waits;
    wait_cfg = 4'd5;
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h10; PWRITE = 1'b1; PWDATA = 32'hCAFE_F00D; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    wait_cfg = 4'd0;
    @(negedge PCLK);
    #1;
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_wait: got %b need 0", PREADY); end
    idle_cycle();
    idle_cycle();
    checks++; if (regs_out[4*32 +: 32] !== 32'h0 || wr_pulse !== 1'b0) begin
      errors++; $display("FAIL abort_reg4: got %h pulse=%b need 0/0", regs_out[4*32 +: 32], wr_pulse); end
    // FSM must be back in IDLE: a fresh zero-wait read completes normally
    apb_xfer(8'h10, 1'b0, 32'h0, 4'h0, rd, err, waits);
    checks++; if (waits !== 0 || err !== 1'b0 || rd !== 32'h0) begin
      errors++; $display("FAIL abort_idle: got waits=%0d err=%b rd=%h need 0/0/0", waits, err, rd); end
    idle_cycle();
  endtask

  task automatic test_reset_mid_access();
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h14; PWRITE = 1'b1; PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF;
    @(negedge PCLK);
    PENABLE = 1'b1;
    PRESETn = 1'b0;
    #1;
    checks++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got rdy=%b err=%b need 0/0", PREADY, PSLVERR); end
    idle_cycle();
    @(negedge PCLK);
    PRESETn = 1'b1;
    idle_cycle();
    checks++; if (regs_out[5*32 +: 32] !== 32'h0 || wr_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_mid_reg5: got %h pulse=%b need 0/0", regs_out[5*32 +: 32], wr_pulse); end
    checks++; if (regs_out[2*32 +: 32] !== 32'h0) begin
      errors++; $display("FAIL rst_mid_reg2: got %h need 0", regs_out[2*32 +: 32]); end
  endtask

  initial begin
    test_reset();
    test_strobe_write();
    test_wait_states();
    test_errors();
    test_abort();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
